// File: rtl/key_cond_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
// Optional auto-repeat on held keys is enabled by defining AUTO_REPEAT_EN.
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    localparam int DEBOUNCE_20MS_50MHZ       = 1_000_000;
    localparam int REPEAT_DELAY_500MS_50MHZ  = 25_000_000;
    localparam int REPEAT_PERIOD_100MS_50MHZ = 5_000_000;

    // Width of a counter that must hold values up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM and pulse generation.
// Auto-repeat of key_press while held is built only when AUTO_REPEAT_EN is defined.
module key_debounce_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_50MHZ,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debounce_channel: invalid timing parameters");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       pressed_raw;
    key_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

`ifdef AUTO_REPEAT_EN
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_armed_q, rpt_armed_d;
`endif

    assign pressed_raw = ~sync2_q;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
`endif

        case (state_q)
            RELEASED: begin
                if (pressed_raw) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_raw) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!pressed_raw) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
`ifdef AUTO_REPEAT_EN
                // First repeat waits the long delay, later ones the short period.
                else if (rpt_armed_q ? (rpt_cnt_q == RPT_PERIOD_LAST)
                                     : (rpt_cnt_q == RPT_DELAY_LAST)) begin
                    press_d     = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_armed_d = 1'b1;
                end else begin
                    rpt_cnt_d   = rpt_cnt_q + RW'(1);
                    rpt_armed_d = rpt_armed_q;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (pressed_raw) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchroniser resets to "released" so leaving reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
`endif
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS active-low pushbuttons into debounced levels and press/release pulses.
// Define AUTO_REPEAT_EN to re-pulse key_press while a key is held.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_50MHZ,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS_50MHZ
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (CLOCK_50),
            .rst         (Reset),
            .key_n       (KEY[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a streak-counting reference model.
// Define AUTO_REPEAT_EN to build and check the auto-repeat variant.
module tb_key_conditioner;

    localparam int NUM_KEYS = 4;
    localparam int DEB      = 4;
    localparam int RD       = 10;
    localparam int RP       = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_KEYS-1:0] key = '1;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;
    int press_count0 = 0;

    typedef struct {
        bit level;
        int streak;
        int held;
        bit prevp;
        bit press;
        bit rel;
    } model_t;

    typedef struct {
        int                  cycle;
        logic [NUM_KEYS-1:0] level;
        logic [NUM_KEYS-1:0] press;
        logic [NUM_KEYS-1:0] rel;
    } exp_t;

    model_t mdl[NUM_KEYS];
    exp_t   expq[$];

    key_conditioner #(
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50    (clk),
        .Reset       (rst),
        .KEY         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A change is accepted after DEB consecutive samples that disagree with the level.
    function automatic model_t modelStep(input model_t m, input bit p);
        model_t n;
        n = m;
        n.press = 1'b0;
        n.rel   = 1'b0;
        if (p != n.level) begin
            n.streak = n.streak + 1;
            if (n.streak == DEB) begin
                n.level  = p;
                n.streak = 0;
                n.held   = 0;
                if (p) n.press = 1'b1;
                else   n.rel   = 1'b1;
            end
        end else begin
            n.streak = 0;
`ifdef AUTO_REPEAT_EN
            if (n.level) begin
                if (n.prevp) n.held = n.held + 1;
                else         n.held = 0;
                if (n.held == RD || (n.held > RD && (n.held - RD) % RP == 0))
                    n.press = 1'b1;
            end
`endif
        end
        n.prevp = p;
        return n;
    endfunction

    function automatic exp_t predict(input int tag);
        exp_t   e;
        model_t n;
        e.cycle = tag;
        e.level = '0;
        e.press = '0;
        e.rel   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            n = modelStep(mdl[k], ~key[k]);
            e.level[k] = n.level;
            e.press[k] = n.press;
            e.rel[k]   = n.rel;
        end
        return e;
    endfunction

    // Key sampled now shows up at the outputs two edges later, after the synchroniser.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expq.delete();
            for (int k = 0; k < NUM_KEYS; k++) mdl[k] <= '{default: 0};
        end else begin
            expq.push_back(predict(cyc + 3));
            for (int k = 0; k < NUM_KEYS; k++) mdl[k] <= modelStep(mdl[k], ~key[k]);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e.cycle = cyc;
        e.level = '0;
        e.press = '0;
        e.rel   = '0;
        if (expq.size() > 0 && expq[0].cycle == cyc) e = expq.pop_front();
        checkOutput("key_level",   int'(key_level),   int'(e.level));
        checkOutput("key_press",   int'(key_press),   int'(e.press));
        checkOutput("key_release", int'(key_release), int'(e.rel));
        if (key_press[0]) press_count0++;
    end

    task automatic applyStimulus(input logic [NUM_KEYS-1:0] keys, input int cycles);
        key = keys;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_KEYS-1:0] rnd_keys;
        int exp_presses;

        key = '1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(4'b1111, 20);

        applyStimulus(4'b1110, 20);
        applyStimulus(4'b1111, 15);

        applyStimulus(4'b1101, 2);
        applyStimulus(4'b1111, 12);

        applyStimulus(4'b0011, 10);
        applyStimulus(4'b1111, 12);

        applyStimulus(4'b1110, 12);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(4'b1110, 12);
        applyStimulus(4'b1111, 12);

        press_count0 = 0;
        applyStimulus(4'b1110, 40);
        applyStimulus(4'b1111, 15);
`ifdef AUTO_REPEAT_EN
        exp_presses = 7;
`else
        exp_presses = 1;
`endif
        checkOutput("held_press_count", press_count0, exp_presses);

        rnd_keys = '1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NUM_KEYS; k++)
                if ($urandom_range(0, 5) == 0) rnd_keys[k] = ~rnd_keys[k];
            if ($urandom_range(0, 19) == 0)
                applyStimulus(rnd_keys, int'($urandom_range(5, 25)));
            else
                applyStimulus(rnd_keys, 1);
        end
        applyStimulus(4'b1111, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
